// File: rtl/alu_ctrl_pkg.sv
// Shared ALU opcodes and execute-unit state encoding.
// Imported by the ALU control decoder and the execute unit.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shift_op_e;

    function automatic logic is_shift(input logic [3:0] c);
        return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle of the execute-stage ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle.
module alu_serial_shifter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    localparam int SW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  shift_op_e       load_op,
    input  logic [XLEN-1:0] load_val,
    input  logic [SW-1:0]   load_amt,
    output logic [XLEN-1:0] next_val,
    output logic            done
);

    localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

    logic [XLEN-1:0] work_q, work_d;
    logic [SW-1:0]   rem_q, rem_d;
    shift_op_e       op_q, op_d;
    logic [SW-1:0]   step;

    always_comb begin
        step = (rem_q > STEP) ? STEP : rem_q;
        unique case (op_q)
            SH_LL:   next_val = work_q << step;
            SH_RL:   next_val = work_q >> step;
            // msb never changes under >>>, so it stays the original sign
            default: next_val = $signed(work_q) >>> step;
        endcase
        done = (rem_q != '0) && (rem_q <= STEP);
    end

    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        op_d   = op_q;
        if (clear) begin
            rem_d = '0;
        end else if (load) begin
            work_d = load_val;
            rem_d  = load_amt;
            op_d   = load_op;
        end else if (rem_q != '0) begin
            work_d = next_val;
            rem_d  = rem_q - step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            rem_q  <= '0;
            op_q   <= SH_LL;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            op_q   <= op_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus multi-cycle serial shifts,
// valid/ready on both sides, registered result/zero/illegal.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    alu_exec_unit_if.slave bus
);

    localparam int SW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_legal;
    logic [SW-1:0]   shamt;
    shift_op_e       sh_op;
    logic            sh_load;
    logic [XLEN-1:0] sh_next;
    logic            sh_done;
    logic            in_ready;

    assign shamt    = bus.src_b[SW-1:0];
    assign in_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_HOLD) && bus.out_ready);

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        unique case (bus.alu_ctrl)
            ALU_AND:  alu_res = bus.src_a & bus.src_b;
            ALU_OR:   alu_res = bus.src_a | bus.src_b;
            ALU_ADD:  alu_res = bus.src_a + bus.src_b;
            ALU_SUB:  alu_res = bus.src_a - bus.src_b;
            ALU_XOR:  alu_res = bus.src_a ^ bus.src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                 $signed(bus.src_a) < $signed(bus.src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
            // only reached with shamt == 0
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.src_a;
            default:  alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        unique case (bus.alu_ctrl)
            ALU_SLL: sh_op = SH_LL;
            ALU_SRL: sh_op = SH_RL;
            default: sh_op = SH_RA;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        sh_load   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_SHIFT: begin
                    if (sh_done) begin
                        result_d  = sh_next;
                        zero_d    = (sh_next == '0);
                        illegal_d = 1'b0;
                        state_d   = ST_HOLD;
                    end
                end
                default: begin
                    if (bus.in_valid && in_ready) begin
                        if (is_shift(bus.alu_ctrl) && (shamt != '0)) begin
                            sh_load = 1'b1;
                            state_d = ST_SHIFT;
                        end else begin
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = !alu_legal;
                            state_d   = ST_HOLD;
                        end
                    end else if (state_q == ST_HOLD && bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    alu_serial_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .load     (sh_load),
        .load_op  (sh_op),
        .load_val (bus.src_a),
        .load_amt (shamt),
        .next_val (sh_next),
        .done     (sh_done)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Random + directed bench for alu_exec_unit, two shift-step variants.
module tb_alu_exec_unit;
    import alu_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        iv[2];
    logic        ordy[2];
    logic [3:0]  ctl;
    logic [31:0] sa, sb;
    logic        ov[2], irdy[2], zr[2], il[2];
    logic [31:0] res[2];

    int n_chk;
    int n_pass;

    alu_exec_unit_if #(.XLEN(32)) bus0 ();
    alu_exec_unit_if #(.XLEN(32)) bus1 ();

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0.slave)
    );
    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1.slave)
    );

    assign bus0.in_valid  = iv[0];
    assign bus0.out_ready = ordy[0];
    assign bus0.alu_ctrl  = ctl;
    assign bus0.src_a     = sa;
    assign bus0.src_b     = sb;
    assign bus1.in_valid  = iv[1];
    assign bus1.out_ready = ordy[1];
    assign bus1.alu_ctrl  = ctl;
    assign bus1.src_a     = sa;
    assign bus1.src_b     = sb;

    assign ov[0]   = bus0.out_valid;
    assign irdy[0] = bus0.in_ready;
    assign zr[0]   = bus0.zero;
    assign il[0]   = bus0.illegal;
    assign res[0]  = bus0.result;
    assign ov[1]   = bus1.out_valid;
    assign irdy[1] = bus1.in_ready;
    assign zr[1]   = bus1.zero;
    assign il[1]   = bus1.illegal;
    assign res[1]  = bus1.result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1100: return a ^ b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: return (a < b) ? 32'd1 : 32'd0;
            4'b1110: return a << sh;
            4'b1101: return a >> sh;
            4'b1111: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [3:0] c);
        return !(c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100,
                           4'b0111, 4'b1001, 4'b1110, 4'b1101, 4'b1111});
    endfunction

    function automatic int ref_lat(input int k, input logic [3:0] c,
                                   input logic [31:0] b);
        int sh, st;
        sh = int'(b % 32);
        st = (k == 0) ? 1 : 8;
        if (c inside {4'b1110, 4'b1101, 4'b1111} && sh != 0)
            return (sh + st - 1) / st + 1;
        return 1;
    endfunction

    task automatic run_op(input int k, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        int lat, elat;
        logic held;
        er   = ref_res(c, a, b);
        elat = ref_lat(k, c, b);
        chk("rdy_pre", 32'(irdy[k]), 32'd1);
        ctl = c; sa = a; sb = b;
        iv[k] = 1'b1; ordy[k] = 1'b0;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        ctl = 4'($urandom); sa = $urandom; sb = $urandom;
        lat = 1; held = 1'b1;
        while (!ov[k] && lat < 100) begin
            if (irdy[k]) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("result", res[k], er);
        chk("zero", 32'(zr[k]), 32'(er == 32'd0));
        chk("illegal", 32'(il[k]), 32'(ref_ill(c)));
        if (elat > 1) chk("shift_stall", 32'(held), 32'd1);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk("drain", 32'(ov[k]), 32'd0);
    endtask

    logic [3:0] codes[10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100,
                              4'b0111, 4'b1001, 4'b1110, 4'b1101, 4'b1111};

    initial begin
        logic [3:0] c;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; flush = 1'b0;
        iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b0; ordy[1] = 1'b0;
        ctl = 4'd0; sa = 32'd0; sb = 32'd0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ov", 32'(ov[k]), 32'd0);
            chk("rst_res", res[k], 32'd0);
            chk("rst_zero", 32'(zr[k]), 32'd0);
            chk("rst_ill", 32'(il[k]), 32'd0);
            chk("rst_rdy", 32'(irdy[k]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 2; k++) begin
            run_op(k, ALU_ADD, 32'h7FFFFFFF, 32'h1);
            run_op(k, ALU_ADD, 32'hFFFFFFFF, 32'h1);
            run_op(k, ALU_SUB, 32'd5, 32'd5);
            run_op(k, ALU_SLT, 32'hFFFFFFFF, 32'h1);
            run_op(k, ALU_SLTU, 32'hFFFFFFFF, 32'h1);
            run_op(k, ALU_SRA, 32'h80000000, 32'd4);
            run_op(k, ALU_SLL, 32'h1, 32'd31);
            run_op(k, ALU_SRL, 32'hDEADBEEF, 32'hFFFFFFE0);
            run_op(k, 4'b0011, 32'h1234, 32'h5678);
        end

        repeat (60) begin
            for (int k = 0; k < 2; k++) begin
                c = codes[$urandom_range(0, 9)];
                if ($urandom_range(0, 9) == 0) c = 4'($urandom);
                run_op(k, c, $urandom, $urandom);
            end
        end

        // stall in HOLD, then back-to-back accept
        ctl = ALU_ADD; sa = 32'd3; sb = 32'd4;
        iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("hold_ov", 32'(ov[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_res", res[0], 32'd7);
        chk("hold_rdy", 32'(irdy[0]), 32'd0);
        chk("hold_ov3", 32'(ov[0]), 32'd1);
        ctl = ALU_XOR; sa = 32'hF0; sb = 32'hFF;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1 chk("b2b_rdy", 32'(irdy[0]), 32'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("b2b_ov", 32'(ov[0]), 32'd1);
        chk("b2b_res", res[0], 32'h0F);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;

        // flush mid-shift
        ctl = ALU_SRL; sa = 32'hF0000000; sb = 32'd20;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_shift_rdy", 32'(irdy[0]), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ov", 32'(ov[0]), 32'd0);
        chk("flush_rdy", 32'(irdy[0]), 32'd1);
        chk("flush_res", res[0], 32'h0F);
        repeat (25) @(posedge clk);
        #1;
        chk("flush_late", 32'(ov[0]), 32'd0);

        // flush discards a same-cycle accept
        ctl = ALU_ADD; sa = 32'd1; sb = 32'd1;
        iv[0] = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; flush = 1'b0;
        chk("flush_acc_ov", 32'(ov[0]), 32'd0);
        chk("flush_acc_res", res[0], 32'h0F);

        // async reset mid-shift
        ctl = ALU_SRA; sa = 32'h80000000; sb = 32'd10;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_res", res[0], 32'd0);
        chk("arst_ov", 32'(ov[0]), 32'd0);
        chk("arst_rdy", 32'(irdy[0]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("arst_no_res", 32'(ov[0]), 32'd0);
        run_op(0, ALU_SRA, 32'h80000000, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
